// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LATENCY_MAX  = 8;
    localparam int N_LEGAL_STRB = 7;

    // Byte, aligned half-word and full-word strobes are the only legal write shapes.
    localparam logic [3:0] LEGAL_STRB [N_LEGAL_STRB] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
    };

    function automatic logic is_legal_strb(input logic [3:0] strb);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < N_LEGAL_STRB; i++) begin
            if (strb == LEGAL_STRB[i]) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [3:0][7:0] r_mem [DEPTH_WORDS];

    // Lane-selective write; the read register only moves on an access.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    r_mem[idx][i] <= wdata[8*i +: 8];
                end
            end
            rdata <= r_mem[idx];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready request, programmable latency, backpressured response.
// Define DMEM_STRB_CHECK_EN to reject write strobes outside the legal byte/half/word set.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_rvalid,
    input  logic        mem_rready,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY_MAX);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_err;
    logic             r_is_wr;

    logic [29:0]      w_word_off;
    logic             w_oor, w_strb_bad, w_req_err, w_accept, w_access, w_use_req;
    logic [IDX_W-1:0] w_arr_idx;
    logic [31:0]      w_arr_wdata, w_arr_rdata;
    logic [3:0]       w_arr_we;
    logic             w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^mem_addr[1:0];

    // BASE_ADDR is word aligned, so word-granular compare and subtract suffice.
    assign w_word_off = mem_addr[31:2] - BASE_ADDR[31:2];
    assign w_oor      = (mem_addr[31:2] < BASE_ADDR[31:2]) || (w_word_off >= 30'(DEPTH_WORDS));

`ifdef DMEM_STRB_CHECK_EN
    assign w_strb_bad = (mem_wstrb != 4'b0000) && !is_legal_strb(mem_wstrb);
`else
    assign w_strb_bad = 1'b0;
`endif

    assign w_req_err = w_oor | w_strb_bad;
    assign mem_ready = (r_state == IDLE) | ((r_state == RESP) & mem_rready);
    assign w_accept  = mem_valid & mem_ready;

    // Next-state logic; with LATENCY==1 the access uses the live request on the accepting edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        w_use_req   = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (LATENCY > 1) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end else begin
                        w_state_nxt = RESP;
                        w_access    = 1'b1;
                        w_use_req   = 1'b1;
                    end
                end else if ((r_state == RESP) && mem_rready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                    w_access    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Array port selection; erroring requests never raise a byte enable.
    always_comb begin
        w_arr_idx   = r_idx;
        w_arr_wdata = r_wdata;
        w_arr_we    = 4'b0000;
        if (w_use_req) begin
            w_arr_idx   = w_word_off[IDX_W-1:0];
            w_arr_wdata = mem_wdata;
            w_arr_we    = (w_access && !w_req_err) ? mem_wstrb : 4'b0000;
        end else begin
            w_arr_we    = (w_access && !r_err) ? r_wstrb : 4'b0000;
        end
    end

    // State and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request capture at the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_wdata <= 32'h0000_0000;
            r_wstrb <= 4'b0000;
            r_err   <= 1'b0;
            r_is_wr <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_word_off[IDX_W-1:0];
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_err   <= w_req_err;
            r_is_wr <= (mem_wstrb != 4'b0000);
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (w_access),
        .we    (w_arr_we),
        .idx   (w_arr_idx),
        .wdata (w_arr_wdata),
        .rdata (w_arr_rdata)
    );

    assign mem_rvalid = (r_state == RESP);
    assign mem_err    = mem_rvalid & r_err;
    assign mem_rdata  = (mem_rvalid && !r_err && !r_is_wr) ? w_arr_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (LATENCY 1, 4, 3) against a transaction-level model.
module tb_dmem_resp;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_STRB_CHECK_EN
    localparam logic STRB_CHK = 1'b1;
`else
    localparam logic STRB_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid [3], ready [3], rvalid [3], rready [3], err [3];
    logic [31:0] addr [3], wdata [3], rdata [3];
    logic [3:0]  wstrb [3];
    int          cyc = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .mem_valid(valid[0]), .mem_ready(ready[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_rvalid(rvalid[0]), .mem_rready(rready[0]), .mem_rdata(rdata[0]), .mem_err(err[0]));
    dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .mem_valid(valid[1]), .mem_ready(ready[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_rvalid(rvalid[1]), .mem_rready(rready[1]), .mem_rdata(rdata[1]), .mem_err(err[1]));
    dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .mem_valid(valid[2]), .mem_ready(ready[2]),
        .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]),
        .mem_rvalid(rvalid[2]), .mem_rready(rready[2]), .mem_rdata(rdata[2]), .mem_err(err[2]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic req_err(input logic [31:0] a, input logic [3:0] s);
        logic e;
        e = (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
        if (STRB_CHK && (s != 4'b0000) &&
            !(s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}))
            e = 1'b1;
        return e;
    endfunction

    // Outstanding request per instance: one at most, strictly in order.
    typedef struct {
        logic        v;
        int          acc;
        logic [31:0] rd;
        logic        er;
        logic        wr;
        int          idx;
        logic [31:0] d;
        logic [3:0]  s;
        logic        applied;
    } pend_t;

    pend_t       pend [3];
    logic [31:0] mdl [3][DEPTH];

    // Model: a response is visible from LATENCY cycles after the accept cycle until its handshake.
    always @(negedge clk) begin : cmp
        logic        vis, exp_ready, e;
        logic [31:0] w;
        int          idx;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                chk($sformatf("i%0d_rst_rvalid", k), 32'(rvalid[k]), 32'h0);
                chk($sformatf("i%0d_rst_rdata", k), rdata[k], 32'h0);
                chk($sformatf("i%0d_rst_err", k), 32'(err[k]), 32'h0);
                pend[k].v = 1'b0;
            end else begin
                vis = pend[k].v && ((cyc - pend[k].acc) >= lat_of(k));
                if (vis && !pend[k].applied) begin
                    if (pend[k].wr && !pend[k].er) begin
                        w = mdl[k][pend[k].idx];
                        for (int b = 0; b < 4; b++)
                            if (pend[k].s[b]) w[8*b +: 8] = pend[k].d[8*b +: 8];
                        mdl[k][pend[k].idx] = w;
                    end
                    pend[k].applied = 1'b1;
                end
                chk($sformatf("i%0d_rvalid", k), 32'(rvalid[k]), 32'(vis));
                if (vis) begin
                    chk($sformatf("i%0d_rdata", k), rdata[k], pend[k].rd);
                    chk($sformatf("i%0d_err", k), 32'(err[k]), 32'(pend[k].er));
                end
                exp_ready = !pend[k].v || (vis && rready[k]);
                chk($sformatf("i%0d_ready", k), 32'(ready[k]), 32'(exp_ready));
                if (vis && rready[k]) pend[k].v = 1'b0;
                if (valid[k] && exp_ready) begin
                    e   = req_err(addr[k], wstrb[k]);
                    idx = e ? 0 : int'((addr[k] - BASE) >> 2);
                    pend[k].v       = 1'b1;
                    pend[k].acc     = cyc;
                    pend[k].er      = e;
                    pend[k].wr      = (wstrb[k] != 4'b0000);
                    pend[k].idx     = idx;
                    pend[k].d       = wdata[k];
                    pend[k].s       = wstrb[k];
                    pend[k].applied = 1'b0;
                    pend[k].rd      = (e || pend[k].wr) ? 32'h0 : mdl[k][idx];
                end
            end
        end
    end

    // One request with hand-computed response; rready held low for 'hold' extra cycles.
    task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold,
                          input logic [31:0] er, input logic ee);
        int t0, t1, n;
        valid[k] = 1'b1; addr[k] = a; wdata[k] = d; wstrb[k] = s; rready[k] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ready[k] && n < 20) begin n++; @(negedge clk); end
        t0 = cyc;
        chk("req_accept", 32'(ready[k]), 32'h1);
        @(posedge clk); #1;
        valid[k] = 1'b0; addr[k] = 32'hFFFF_FFFC; wdata[k] = 32'hA5A5_A5A5; wstrb[k] = 4'b1111;
        n = 0;
        @(negedge clk);
        while (!rvalid[k] && n < 20) begin n++; @(negedge clk); end
        t1 = cyc;
        chk("resp_valid", 32'(rvalid[k]), 32'h1);
        chk("resp_latency", 32'(t1 - t0), 32'(lat_of(k)));
        chk("resp_rdata", rdata[k], er);
        chk("resp_err", 32'(err[k]), 32'(ee));
        repeat (hold) @(posedge clk);
        @(posedge clk); #1 rready[k] = 1'b1;
        @(posedge clk); #1 rready[k] = 1'b0;
    endtask

    // Eight back-to-back requests with rready held high; expected data exp0 + step*n.
    task automatic burst(input int k, input logic [3:0] s, input logic [31:0] a0,
                         input logic [31:0] d0, input logic [31:0] exp0, input logic [31:0] step);
        int seen;
        seen = 0;
        rready[k] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid[k] = 1'b1; addr[k] = a0 + 32'(4 * i); wdata[k] = d0 + 32'(i); wstrb[k] = s;
            @(negedge clk);
            chk("b2b_ready", 32'(ready[k]), 32'h1);
            if (rvalid[k]) begin
                chk("b2b_data", rdata[k], exp0 + step * 32'(seen));
                seen++;
            end
            @(posedge clk); #1;
        end
        valid[k] = 1'b0;
        @(negedge clk);
        if (rvalid[k]) begin
            chk("b2b_data", rdata[k], exp0 + step * 32'(seen));
            seen++;
        end
        chk("b2b_count", 32'(seen), 32'h8);
        @(posedge clk); #1 rready[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0; rready[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0; wstrb[k] = 4'b0000;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_reset_ready", 32'(ready[0]), 32'h1);

        do_req(0, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0, 1'b0);
        do_req(0, 32'h10, 32'h0,         4'b0000, 0, 32'hDEAD_BEEF, 1'b0);

        do_req(0, 32'h20, 32'h1122_3344, 4'b1111, 0, 32'h0, 1'b0);
        do_req(0, 32'h20, 32'h0000_AA00, 4'b0010, 0, 32'h0, 1'b0);
        do_req(0, 32'h23, 32'h0,         4'b0000, 0, 32'h1122_AA44, 1'b0);

        do_req(0, 32'h20, 32'h9988_7766, 4'b0101, 0, 32'h0, STRB_CHK);
        do_req(0, 32'h20, 32'h0, 4'b0000, 0, STRB_CHK ? 32'h1122_AA44 : 32'h1188_AA66, 1'b0);

        do_req(0, 32'h0,   32'h0BAD_F00D, 4'b1111, 0, 32'h0, 1'b0);
        do_req(0, 32'h100, 32'h0,         4'b0000, 0, 32'h0, 1'b1);
        do_req(0, 32'h100, 32'hFFFF_FFFF, 4'b1111, 0, 32'h0, 1'b1);
        do_req(0, 32'h0,   32'h0,         4'b0000, 0, 32'h0BAD_F00D, 1'b0);

        do_req(1, 32'h8, 32'h1234_5678, 4'b1111, 0, 32'h0, 1'b0);
        do_req(1, 32'h8, 32'h0,         4'b0000, 2, 32'h1234_5678, 1'b0);

        burst(0, 4'b1111, 32'h40, 32'h0000_A000, 32'h0, 32'h0);
        burst(0, 4'b0000, 32'h40, 32'h0,         32'h0000_A000, 32'h1);

        do_req(2, 32'h0, 32'hCAFE_F00D, 4'b1111, 0, 32'h0, 1'b0);
        valid[2] = 1'b1; addr[2] = 32'h0; wdata[2] = 32'h0000_0055; wstrb[2] = 4'b1111;
        @(negedge clk);
        chk("rw_accept_ready", 32'(ready[2]), 32'h1);
        @(posedge clk); #1 valid[2] = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_wait_rvalid", 32'(rvalid[2]), 32'h0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        do_req(2, 32'h0, 32'h0, 4'b0000, 0, 32'hCAFE_F00D, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
